// File: rtl/cpu_clock_controller.sv
// CPU clock generator: free-run, N-cycle step bursts and halt, with debounced buttons,
// PC breakpoint and glitch-free stop. Define CLOCK_CYCLE_COUNTER_EN to add o_CYCLE_COUNT.
module cpu_clock_controller #(
    parameter int CLOCK_DIVIDER     = 2,
    parameter int DEBOUNCE_CYCLES   = 4,
    parameter int STEP_COUNT_WIDTH  = 8,
    parameter int ADDRESS_WIDTH     = 4,
    parameter int CYCLE_COUNT_WIDTH = 32
) (
    input  logic                         i_SYS_CLOCK,
    input  logic                         i_RESET_n,
    input  logic                         i_HALT,
    input  logic                         i_MODE_TOGGLE,
    input  logic                         i_STEP,
    input  logic [STEP_COUNT_WIDTH-1:0]  i_STEP_COUNT,
    input  logic                         i_BREAK_ENABLE,
    input  logic [ADDRESS_WIDTH-1:0]     i_BREAK_ADDRESS,
    input  logic [ADDRESS_WIDTH-1:0]     i_PC,
`ifdef CLOCK_CYCLE_COUNTER_EN
    output logic [CYCLE_COUNT_WIDTH-1:0] o_CYCLE_COUNT,
`endif
    output logic                         o_CLOCK,
    output logic                         o_CLOCK_n,
    output logic                         o_TICK,
    output logic                         o_RUNNING,
    output logic                         o_HALTED,
    output logic                         o_BREAK_HIT
);
    localparam int PW = (CLOCK_DIVIDER > 1) ? $clog2(CLOCK_DIVIDER) : 1;
    localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);

    typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_BURST, ST_HALTED} state_t;

    logic [1:0] raw_buttons;
    logic [1:0] press;
    logic       mode_press;
    logic       step_press;

    assign raw_buttons = {i_STEP, i_MODE_TOGGLE};
    assign mode_press  = press[0];
    assign step_press  = press[1];

    // The debounced level only moves once the synchronised sample has disagreed with it
    // for DEBOUNCE_CYCLES samples in a row; any agreeing sample restarts the count.
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_debounce
            logic          sync1_reg;
            logic          sync2_reg;
            logic          level_reg;
            logic          level_d_reg;
            logic [DW-1:0] stable_cnt_reg;

            always_ff @(posedge i_SYS_CLOCK or negedge i_RESET_n) begin
                if (!i_RESET_n) begin
                    sync1_reg      <= 1'b0;
                    sync2_reg      <= 1'b0;
                    level_reg      <= 1'b0;
                    level_d_reg    <= 1'b0;
                    stable_cnt_reg <= '0;
                end else begin
                    sync1_reg   <= raw_buttons[gi];
                    sync2_reg   <= sync1_reg;
                    level_d_reg <= level_reg;
                    if (sync2_reg == level_reg) begin
                        stable_cnt_reg <= '0;
                    end else if (stable_cnt_reg == DW'(DEBOUNCE_CYCLES - 1)) begin
                        level_reg      <= sync2_reg;
                        stable_cnt_reg <= '0;
                    end else begin
                        stable_cnt_reg <= stable_cnt_reg + DW'(1);
                    end
                end
            end

            assign press[gi] = level_reg & ~level_d_reg;
        end
    endgenerate

    state_t                      state_reg;
    logic [PW-1:0]               presc_reg;
    logic                        clk_reg;
    logic                        tick_reg;
    logic [STEP_COUNT_WIDTH-1:0] remaining_reg;
    logic                        stop_req_reg;
    logic                        bp_suppress_reg;
    logic                        break_hit_reg;
    logic                        terminal;
    logic                        is_run;

    assign terminal = (presc_reg == PW'(CLOCK_DIVIDER - 1));
    assign is_run   = (state_reg == ST_RUN);

    always_ff @(posedge i_SYS_CLOCK or negedge i_RESET_n) begin
        if (!i_RESET_n) begin
            state_reg       <= ST_IDLE;
            presc_reg       <= '0;
            clk_reg         <= 1'b0;
            tick_reg        <= 1'b0;
            remaining_reg   <= '0;
            stop_req_reg    <= 1'b0;
            bp_suppress_reg <= 1'b0;
            break_hit_reg   <= 1'b0;
        end else begin
            tick_reg <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    presc_reg <= '0;
                    clk_reg   <= 1'b0;
                    if (mode_press) begin
                        state_reg       <= ST_RUN;
                        bp_suppress_reg <= 1'b1;
                        stop_req_reg    <= 1'b0;
                        break_hit_reg   <= 1'b0;
                    end else if (step_press) begin
                        state_reg     <= ST_BURST;
                        remaining_reg <= (i_STEP_COUNT == '0) ? STEP_COUNT_WIDTH'(1) : i_STEP_COUNT;
                        break_hit_reg <= 1'b0;
                    end
                end
                ST_RUN, ST_BURST: begin
                    if (is_run && mode_press)
                        stop_req_reg <= 1'b1;
                    if (!terminal) begin
                        presc_reg <= presc_reg + PW'(1);
                    end else begin
                        presc_reg <= '0;
                        if (clk_reg) begin
                            // Falling edge: never cut short, so stops only happen while low.
                            clk_reg <= 1'b0;
                            if (!is_run && remaining_reg == '0)
                                state_reg <= ST_IDLE;
                        end else if (i_HALT) begin
                            state_reg <= ST_HALTED;
                        end else if (is_run && stop_req_reg) begin
                            state_reg    <= ST_IDLE;
                            stop_req_reg <= 1'b0;
                        end else if (is_run && i_BREAK_ENABLE && (i_PC == i_BREAK_ADDRESS)
                                     && !bp_suppress_reg) begin
                            state_reg     <= ST_IDLE;
                            break_hit_reg <= 1'b1;
                        end else begin
                            clk_reg         <= 1'b1;
                            tick_reg        <= 1'b1;
                            bp_suppress_reg <= 1'b0;
                            if (!is_run)
                                remaining_reg <= remaining_reg - STEP_COUNT_WIDTH'(1);
                        end
                    end
                end
                default: begin
                    presc_reg <= '0;
                    clk_reg   <= 1'b0;
                end
            endcase
        end
    end

`ifdef CLOCK_CYCLE_COUNTER_EN
    logic [CYCLE_COUNT_WIDTH-1:0] cycle_count_reg;

    always_ff @(posedge i_SYS_CLOCK or negedge i_RESET_n) begin
        if (!i_RESET_n)
            cycle_count_reg <= '0;
        else if (tick_reg)
            cycle_count_reg <= cycle_count_reg + CYCLE_COUNT_WIDTH'(1);
    end

    assign o_CYCLE_COUNT = cycle_count_reg;
`endif

    assign o_CLOCK     = clk_reg;
    assign o_CLOCK_n   = ~clk_reg;
    assign o_TICK      = tick_reg;
    assign o_RUNNING   = (state_reg == ST_RUN) || (state_reg == ST_BURST);
    assign o_HALTED    = (state_reg == ST_HALTED);
    assign o_BREAK_HIT = break_hit_reg;

endmodule

// File: tb/tb_cpu_clock_controller.sv
// Self-checking bench for cpu_clock_controller: burst table plus run/break/halt/glitch/reset sequences.
module tb_cpu_clock_controller;
    localparam int CD  = 2;
    localparam int DB  = 4;
    localparam int SCW = 8;
    localparam int AW  = 4;
    localparam int CCW = 32;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           halt = 1'b0;
    logic           mode_btn = 1'b0;
    logic           step_btn = 1'b0;
    logic [SCW-1:0] step_count = '0;
    logic           brk_en = 1'b0;
    logic [AW-1:0]  brk_addr = '0;
    logic [AW-1:0]  pc;
    logic           o_clock, o_clock_n, o_tick, o_running, o_halted, o_break_hit;
`ifdef CLOCK_CYCLE_COUNTER_EN
    logic [CCW-1:0] o_cycle_count;
`endif

    cpu_clock_controller #(
        .CLOCK_DIVIDER(CD), .DEBOUNCE_CYCLES(DB), .STEP_COUNT_WIDTH(SCW),
        .ADDRESS_WIDTH(AW), .CYCLE_COUNT_WIDTH(CCW)
    ) dut (
        .i_SYS_CLOCK(clk), .i_RESET_n(rst_n), .i_HALT(halt),
        .i_MODE_TOGGLE(mode_btn), .i_STEP(step_btn), .i_STEP_COUNT(step_count),
        .i_BREAK_ENABLE(brk_en), .i_BREAK_ADDRESS(brk_addr), .i_PC(pc),
`ifdef CLOCK_CYCLE_COUNTER_EN
        .o_CYCLE_COUNT(o_cycle_count),
`endif
        .o_CLOCK(o_clock), .o_CLOCK_n(o_clock_n), .o_TICK(o_tick),
        .o_RUNNING(o_running), .o_HALTED(o_halted), .o_BREAK_HIT(o_break_hit)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail = 0;
    int tick_total = 0;
    int cyc = 0;
    int hi_len = 0;
    int runt_err = 0;
    int inv_err = 0;

    // Monitor: counts ticks, models a PC that advances once per CPU clock, and
    // checks every completed high phase is exactly CD system cycles.
    always @(negedge clk) begin
        cyc = cyc + 1;
        if (o_clock_n !== ~o_clock) inv_err = inv_err + 1;
        if (!rst_n) begin
            hi_len = 0;
            pc = '0;
        end else begin
            if (o_tick) begin
                tick_total = tick_total + 1;
                pc = pc + 1'b1;
            end
            if (o_clock) hi_len = hi_len + 1;
            else if (hi_len != 0) begin
                if (hi_len != CD) runt_err = runt_err + 1;
                hi_len = 0;
            end
        end
    end

    typedef struct {
        logic [SCW-1:0] count;
        int             exp_ticks;
    } burst_vec_t;
    burst_vec_t vecs[4];

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    task automatic do_reset();
        mode_btn = 1'b0;
        step_btn = 1'b0;
        halt     = 1'b0;
        rst_n    = 1'b0;
        cycles(3);
        rst_n = 1'b1;
        cycles(4);
    endtask

    function automatic logic get_sig(input int sel);
        case (sel)
            0: return o_clock;
            1: return o_running;
            2: return o_halted;
            default: return o_tick;
        endcase
    endfunction

    task automatic wait_for(input int sel, input logic val, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (get_sig(sel) == val) begin
                ok = 1'b1;
                break;
            end
            cycles(1);
        end
    endtask

    initial begin
        bit ok;
        int t0, t1, t2, t3;

        vecs[0] = '{count: 8'd3, exp_ticks: 3};
        vecs[1] = '{count: 8'd0, exp_ticks: 1};
        vecs[2] = '{count: 8'd1, exp_ticks: 1};
        vecs[3] = '{count: 8'd5, exp_ticks: 5};

        // Reset state
        cycles(2);
        check("rst_clock", o_clock, 0);
        check("rst_clock_n", o_clock_n, 1);
        check("rst_tick", o_tick, 0);
        check("rst_running", o_running, 0);
        check("rst_halted", o_halted, 0);
        check("rst_break_hit", o_break_hit, 0);
        rst_n = 1'b1;
        cycles(4);

        // Free run, then stop with a second mode press
        do_reset();
        t0 = tick_total;
        mode_btn = 1'b1; cycles(10); mode_btn = 1'b0;
        check("run_running", o_running, 1);
        wait_for(3, 1'b1, 20, ok); check("run_tick1_seen", ok, 1); t1 = cyc; cycles(1);
        wait_for(3, 1'b1, 20, ok); check("run_tick2_seen", ok, 1); t2 = cyc; cycles(1);
        wait_for(3, 1'b1, 20, ok); check("run_tick3_seen", ok, 1); t3 = cyc;
        check("run_period_a", t2 - t1, 2 * CD);
        check("run_period_b", t3 - t2, 2 * CD);
        mode_btn = 1'b1; cycles(10); mode_btn = 1'b0;
        wait_for(1, 1'b0, 40, ok);
        check("stop_seen", ok, 1);
        check("stop_clock_low", o_clock, 0);
        t1 = tick_total;
        cycles(30);
        check("stop_no_ticks", tick_total - t1, 0);
`ifdef CLOCK_CYCLE_COUNTER_EN
        check("cycle_count_run", o_cycle_count, tick_total - t0);
`endif

        // Step bursts from the table
        for (int v = 0; v < 4; v++) begin
            do_reset();
            step_count = vecs[v].count;
            t0 = tick_total;
            step_btn = 1'b1; cycles(6); step_btn = 1'b0;
            cycles(80);
            check($sformatf("burst%0d_ticks", v), tick_total - t0, vecs[v].exp_ticks);
            check($sformatf("burst%0d_clock", v), o_clock, 0);
            check($sformatf("burst%0d_running", v), o_running, 0);
        end

        // Breakpoint at PC 5, then resume past it
        do_reset();
        brk_en = 1'b1; brk_addr = 4'd5;
        t0 = tick_total;
        mode_btn = 1'b1; cycles(10); mode_btn = 1'b0;
        wait_for(1, 1'b0, 100, ok);
        check("brk_stop_seen", ok, 1);
        check("brk_hit", o_break_hit, 1);
        check("brk_pc", pc, 5);
        check("brk_ticks", tick_total - t0, 5);
        cycles(20);
        check("brk_no_more_ticks", tick_total - t0, 5);
        mode_btn = 1'b1; cycles(10); mode_btn = 1'b0;
        check("brk_hit_cleared", o_break_hit, 0);
        ok = 1'b0;
        for (int i = 0; i < 60; i++) begin
            if (pc == 4'd8) begin ok = 1'b1; break; end
            cycles(1);
        end
        check("brk_resume_past", ok, 1);
        brk_en = 1'b0;

        // HALT raised during a high phase
        do_reset();
        mode_btn = 1'b1; cycles(10); mode_btn = 1'b0;
        wait_for(0, 1'b1, 20, ok);
        check("halt_high_seen", ok, 1);
        halt = 1'b1;
        t0 = tick_total;
        wait_for(2, 1'b1, 20, ok);
        check("halt_seen", ok, 1);
        check("halt_no_rise", tick_total - t0, 0);
        check("halt_clock_low", o_clock, 0);
        check("halt_running", o_running, 0);
        mode_btn = 1'b1; step_btn = 1'b1; cycles(10); mode_btn = 1'b0; step_btn = 1'b0;
        cycles(20);
        halt = 1'b0;
        cycles(4);
        check("halt_sticky", o_halted, 1);
        check("halt_buttons_ignored", tick_total - t0, 0);
        rst_n = 1'b0; cycles(2);
        check("halt_reset_cleared", o_halted, 0);
        rst_n = 1'b1; cycles(2);

        // Short step glitches must not start a burst
        do_reset();
        step_count = 8'd3;
        t0 = tick_total;
        for (int w = 1; w <= 3; w++) begin
            for (int r = 0; r < 3; r++) begin
                step_btn = 1'b1; cycles(w); step_btn = 1'b0; cycles(6);
            end
        end
        cycles(10);
        check("glitch_no_ticks", tick_total - t0, 0);
        check("glitch_idle", o_running, 0);
        step_btn = 1'b1; cycles(6); step_btn = 1'b0;
        cycles(60);
        check("glitch_then_burst", tick_total - t0, 3);

        // Asynchronous reset while the clock is high mid-burst
        do_reset();
        step_count = 8'd5;
        step_btn = 1'b1; cycles(6); step_btn = 1'b0;
        wait_for(0, 1'b1, 40, ok);
        check("midburst_high_seen", ok, 1);
        #1 rst_n = 1'b0;
        #1;
        check("midburst_rst_clock", o_clock, 0);
        check("midburst_rst_clock_n", o_clock_n, 1);
        check("midburst_rst_running", o_running, 0);
`ifdef CLOCK_CYCLE_COUNTER_EN
        check("midburst_rst_count", o_cycle_count, 0);
`endif
        cycles(3);
        rst_n = 1'b1;
        cycles(2);

        check("runt_pulses", runt_err, 0);
        check("clock_n_inverse", inv_err, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/cpu_clock_controller.md
Name: cpu_clock_controller

Overview:
Parametrised successor to the CPU clock generation path. It derives the CPU clock from the system clock and offers three modes: free-run, N-cycle step bursts, and halt. It adds debounced control buttons, a PC-match breakpoint and glitch-free stopping. It sits between the board buttons, the control unit's HALT signal and every CPU register clock input.

Parameters:
CLOCK_DIVIDER, 2, system cycles per CPU clock half-period (>=1)
DEBOUNCE_CYCLES, 4, consecutive stable samples required to accept a button level (>=1)
STEP_COUNT_WIDTH, 8, width of the step-burst length input
ADDRESS_WIDTH, 4, width of the PC and breakpoint address
CYCLE_COUNT_WIDTH, 32, width of the optional cycle counter

Ports:
i_SYS_CLOCK  in  1  system clock; the only clock
i_RESET_n  in  1  reset, asynchronous, active-low
i_HALT  in  1  HALT control signal from the control unit
i_MODE_TOGGLE  in  1  raw button; toggles between run and step mode
i_STEP  in  1  raw button; starts a step burst
i_STEP_COUNT  in  STEP_COUNT_WIDTH  CPU cycles per burst; 0 is treated as 1
i_BREAK_ENABLE  in  1  arms the breakpoint
i_BREAK_ADDRESS  in  ADDRESS_WIDTH  breakpoint PC value
i_PC  in  ADDRESS_WIDTH  current program counter
o_CLOCK  out  1  CPU clock
o_CLOCK_n  out  1  always the inverse of o_CLOCK
o_TICK  out  1  one-system-cycle pulse in the cycle where o_CLOCK rises
o_RUNNING  out  1  high in RUN or BURST
o_HALTED  out  1  high in HALTED
o_BREAK_HIT  out  1  sticky breakpoint indication

Behaviour:
- Reset (async, i_RESET_n=0): state IDLE; o_CLOCK=0, o_CLOCK_n=1; o_TICK, o_RUNNING, o_HALTED, o_BREAK_HIT=0; all counters=0; debounced levels=0. Takes effect immediately, including mid-burst or mid-high-phase.
- Debounce (per button): 2-flop synchroniser, then a stability counter. The debounced level updates after DEBOUNCE_CYCLES equal consecutive samples. A rising edge of the debounced level produces a one-cycle press pulse. Any mismatch resets the counter.
- Divider: active only in RUN/BURST. A prescaler counts 0..CLOCK_DIVIDER-1; at terminal count it wraps and o_CLOCK toggles. Period is 2*CLOCK_DIVIDER system cycles. The prescaler is held at 0 in IDLE/HALTED.
- Rising-edge decision point: terminal count while o_CLOCK=0. Checks apply in priority order: HALT, then breakpoint, then normal rise.
- States:
  IDLE: clock held low. Mode press -> RUN with breakpoint check suppressed for the first rise. Step press -> BURST with remaining=max(i_STEP_COUNT,1). Either press clears o_BREAK_HIT.
  RUN: free-running. Mode press sets a stop request; the current high phase completes, and the state goes to IDLE at the next decision point with no rise. Step press is ignored.
  BURST: each rise decrements remaining. After the rise that takes remaining to 0, the falling edge completes and the state goes to IDLE. Breakpoint is not checked. All presses are ignored.
  HALTED: clock low; terminal state until reset; all presses ignored.
- HALT: i_HALT=1 at a decision point (RUN or BURST) suppresses the rise and moves to HALTED. i_HALT is ignored during a high phase.
- Breakpoint: applies in RUN only. At a decision point, if i_BREAK_ENABLE=1 and i_PC==i_BREAK_ADDRESS (and not suppressed), the rise is suppressed, the state goes to IDLE and o_BREAK_HIT is set.
- No runt pulses: o_CLOCK never stops high, and every high phase lasts exactly CLOCK_DIVIDER system cycles.
- Simultaneous mode and step presses in IDLE: mode wins.

Optional Feature:
CLOCK_CYCLE_COUNTER_EN
- Defined: adds output o_CYCLE_COUNT (CYCLE_COUNT_WIDTH). It increments on every o_TICK, wraps modulo 2^CYCLE_COUNT_WIDTH and resets to 0.
- Undefined: the port and counter are absent; all other behaviour is identical.

Test Plan:
- CLOCK_DIVIDER=2, DEBOUNCE_CYCLES=4: reset, then hold i_MODE_TOGGLE for 10 cycles -> RUN, o_CLOCK period 4 cycles, o_TICK every 4 cycles, o_RUNNING=1. Second press -> clock finishes its high phase and stays low, o_RUNNING=0.
- IDLE, i_STEP_COUNT=3, step press -> exactly 3 o_TICK pulses, then o_CLOCK=0 in IDLE. With i_STEP_COUNT=0 -> exactly 1 pulse.
- RUN with i_PC counting 0,1,2... per tick, i_BREAK_ENABLE=1, i_BREAK_ADDRESS=5 -> stop with i_PC=5, no further tick, o_BREAK_HIT=1. Mode press -> o_BREAK_HIT=0 and execution continues past 5.
- i_HALT=1 asserted during a RUN high phase -> that phase completes, no further rise, o_HALTED=1, buttons ignored. Deassert i_RESET_n -> IDLE, o_HALTED=0.
- i_STEP glitches of 1-3 cycles width, repeated -> no burst starts. Stable 6-cycle press -> one burst.
- Deassert i_RESET_n mid-BURST with o_CLOCK=1 -> o_CLOCK=0 immediately, o_CYCLE_COUNT=0 (when CLOCK_CYCLE_COUNTER_EN is defined).
